cmp_bist: RTL and testbench

- Built-in self-test controller that drives the x/y inputs of a W-bit magnitude comparator (eq/gt/lt outputs) and checks its results.
- Sweeps all 2^(2W) operand pairs, with x as the outer loop and y as the inner loop.
- Waits a programmable settle time per pair, then checks the returned flags against an internally computed expectation.
- Reports error count, first failing vector and pass/fail. Sits beside the comparator as its stimulus/checker end, for on-chip or FPGA self-test.

---
 rtl/cmp_bist.sv | 159 +++++++++++++++
 tb/tb_cmp_bist.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cmp_bist.sv
// Self-test controller for a W-bit magnitude comparator: sweeps every (x,y) pair,
// waits SETTLE cycles per pair, checks eq/gt/lt and reports errors and the first failure.
module cmp_bist #(
   parameter int W      = 4,
   parameter int SETTLE = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic [W-1:0]   x_out,
   output logic [W-1:0]   y_out,
   input  logic           eq_in,
   input  logic           gt_in,
   input  logic           lt_in,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2*W:0]   err_count,
   output logic           fail_valid,
   output logic [W-1:0]   fail_x,
   output logic [W-1:0]   fail_y,
   output logic [2:0]     fail_flags
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

   localparam logic [W-1:0] VMAX  = '1;
   localparam logic [W-1:0] VONE  = W'(1);
   localparam logic [2*W:0] EONE  = (2*W+1)'(1);
   localparam logic [3:0]   SLAST = 4'(SETTLE - 1);

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [W-1:0]   x_q, x_d, y_q, y_d;
   logic [2*W:0]   err_q, err_d;
   logic           fv_q, fv_d;
   logic [W-1:0]   fx_q, fx_d, fy_q, fy_d;
   logic [2:0]     ff_q, ff_d;
   logic           busy_q, busy_d, done_q, done_d, pass_q, pass_d;

   logic [2:0]     obs, expf;
   logic           launch;

   assign obs    = {eq_in, gt_in, lt_in};
   assign expf   = {x_q == y_q, x_q > y_q, x_q < y_q};
   // busy stays high through the first DONE cycle, so start is only honoured once results are out
   assign launch = start & ~busy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      ff_d    = ff_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (launch) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               x_d     = '0;
               y_d     = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               fx_d    = '0;
               fy_d    = '0;
               ff_d    = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (state_q == S_DONE && busy_q) begin
               // publish one edge after the last check so pass sees the final count
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_q == '0);
            end
         end
         S_SETTLE: begin
            if (cnt_q == SLAST) begin
               state_d = S_CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (obs != expf) begin
               err_d = err_q + EONE;
               if (!fv_q) begin
                  fv_d = 1'b1;
                  fx_d = x_q;
                  fy_d = y_q;
                  ff_d = obs;
               end
            end
            if (x_q == VMAX && y_q == VMAX) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SETTLE;
               if (y_q != VMAX) begin
                  y_d = y_q + VONE;
               end else begin
                  y_d = '0;
                  x_d = x_q + VONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fx_q    <= '0;
         fy_q    <= '0;
         ff_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         ff_q    <= ff_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign x_out      = x_q;
   assign y_out      = y_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_x     = fx_q;
   assign fail_y     = fy_q;
   assign fail_flags = ff_q;

endmodule

// File: tb/tb_cmp_bist.sv
// Bench for cmp_bist: faulty-comparator models, table of sweeps, scoreboard of expected results.
module tb_cmp_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st1 = 1'b0, st3 = 1'b0;
   int   mode1 = 0, mode3 = 0;
   bit   use3 = 1'b0;
   int   total = 0, bad = 0;

   logic [3:0] x1, y1, x3, y3, fx1, fy1, fx3, fy3;
   logic       eq1, gt1, lt1, eq3, gt3, lt3;
   logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
   logic [8:0] err1, err3;
   logic [2:0] ff1, ff3;

   always #5 clk = ~clk;

   // 0 correct, 1 gt/lt swapped, 2 eq stuck-at-0, 3 lt stuck-at-1
   function automatic logic [2:0] model(input logic [3:0] x, input logic [3:0] y, input int m);
      logic [2:0] r;
      case (m)
         1:       r = {x == y, x < y, x > y};
         2:       r = {1'b0, x > y, x < y};
         3:       r = {x == y, x > y, 1'b1};
         default: r = {x == y, x > y, x < y};
      endcase
      return r;
   endfunction

   assign {eq1, gt1, lt1} = model(x1, y1, mode1);
   assign {eq3, gt3, lt3} = model(x3, y3, mode3);

   cmp_bist #(.W(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .x_out(x1), .y_out(y1),
      .eq_in(eq1), .gt_in(gt1), .lt_in(lt1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_valid(fv1), .fail_x(fx1), .fail_y(fy1), .fail_flags(ff1));

   cmp_bist #(.W(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(st3), .x_out(x3), .y_out(y3),
      .eq_in(eq3), .gt_in(gt3), .lt_in(lt3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_valid(fv3), .fail_x(fx3), .fail_y(fy3), .fail_flags(ff3));

   wire       o_busy = use3 ? busy3 : busy1;
   wire       o_done = use3 ? done3 : done1;
   wire       o_pass = use3 ? pass3 : pass1;
   wire       o_fv   = use3 ? fv3   : fv1;
   wire [8:0] o_err  = use3 ? err3  : err1;
   wire [3:0] o_x    = use3 ? x3    : x1;
   wire [3:0] o_y    = use3 ? y3    : y1;
   wire [3:0] o_fx   = use3 ? fx3   : fx1;
   wire [3:0] o_fy   = use3 ? fy3   : fy1;
   wire [2:0] o_ff   = use3 ? ff3   : ff1;

   typedef struct {
      int   mode;
      bit   s3;
      bit   mid;
      int   edges;
      int   err;
      bit   pass;
      bit   fv;
      int   fx;
      int   fy;
      int   ff;
   } vec_t;

   typedef struct {
      int edges; int err; bit pass; bit fv; int fx; int fy; int ff;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      exp_t e, g;
      int   edges;
      bit   ovl;
      use3 = v.s3;
      if (v.s3) mode3 = v.mode; else mode1 = v.mode;
      e = '{v.edges, v.err, v.pass, v.fv, v.fx, v.fy, v.ff};
      exp_q.push_back(e);
      @(negedge clk);
      if (v.s3) st3 = 1'b1; else st1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st1 = 1'b0;
      st3 = 1'b0;
      check("launch_busy", int'(o_busy), 1);
      check("launch_done", int'(o_done), 0);
      check("launch_err",  int'(o_err), 0);
      check("launch_fv",   int'(o_fv), 0);
      edges = 0;
      ovl   = 1'b0;
      while (!o_done && edges < 3000) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (o_busy && o_done) ovl = 1'b1;
         if (v.mid) begin
            if (v.s3) st3 = (edges == 50); else st1 = (edges == 50);
         end
      end
      st1 = 1'b0;
      st3 = 1'b0;
      g = exp_q.pop_front();
      check("done_edges", edges, g.edges);
      check("busy_done_overlap", int'(ovl), 0);
      check("busy_at_done", int'(o_busy), 0);
      check("err_count", int'(o_err), g.err);
      check("pass", int'(o_pass), int'(g.pass));
      check("fail_valid", int'(o_fv), int'(g.fv));
      check("fail_x", int'(o_fx), g.fx);
      check("fail_y", int'(o_fy), g.fy);
      check("fail_flags", int'(o_ff), g.ff);
      check("x_last", int'(o_x), 15);
      check("y_last", int'(o_y), 15);
      repeat (3) @(negedge clk);
      check("done_held", int'(o_done), 1);
      check("err_held", int'(o_err), g.err);
   endtask

   initial begin
      //           mode s3 mid edges err  pass fv fx fy ff
      tbl[0] = '{0, 0, 0, 513,  0,   1, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 513,  240, 0, 1, 0, 1, 3'b010};
      tbl[2] = '{2, 0, 0, 513,  16,  0, 1, 0, 0, 3'b000};
      tbl[3] = '{3, 0, 0, 513,  136, 0, 1, 0, 0, 3'b101};
      tbl[4] = '{0, 0, 1, 513,  0,   1, 0, 0, 0, 0};
      tbl[5] = '{0, 1, 0, 1025, 0,   1, 0, 0, 0, 0};
      tbl[6] = '{2, 1, 0, 1025, 16,  0, 1, 0, 0, 3'b000};

      #12;
      check("reset_outs1", int'({x1, y1, busy1, done1, pass1, err1, fv1, fx1, fy1, ff1}), 0);
      check("reset_outs3", int'({x3, y3, busy3, done3, pass3, err3, fv3, fx3, fy3, ff3}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_start", int'({busy1, done1}), 0);

      for (int i = 0; i < 7; i++) run(tbl[i]);

      // abort a sweep with reset partway through
      use3  = 1'b0;
      mode1 = 2;
      @(negedge clk);
      st1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st1 = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("pre_abort_busy", int'(busy1), 1);
      rst_n = 1'b0;
      #1;
      check("abort_outs", int'({x1, y1, busy1, done1, pass1, err1, fv1, fx1, fy1, ff1}), 0);
      @(negedge clk);
      check("abort_hold", int'({x1, y1, busy1, done1, err1, fv1}), 0);
      rst_n = 1'b1;
      run(tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
